// File: rtl/video_pkg.sv
// Shared types and constants for the video intensity path.
// Provides intensity and control widths, the envelope FSM state type and the decay-step helper.
package video_pkg;

    localparam int INTENSITY_W = 8;
    localparam int KNOB_W      = 10;
    localparam int STEP_W      = 6;

    typedef logic [INTENSITY_W-1:0] intensity_t;
    typedef logic [KNOB_W-1:0]      knob_t;
    typedef logic [STEP_W-1:0]      step_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        COMMIT
    } env_state_t;

    // Top five control bits select a per-frame decay of 1..32.
    function automatic step_t knob_to_step(input knob_t ctl);
        return step_t'(ctl[KNOB_W-1:KNOB_W-5]) + step_t'(1);
    endfunction

endpackage

// File: rtl/envelope_lane_calc.sv
// Combinational per-instrument envelope step: saturating decay, instant attack, hit hold.
// Ports: e (current envelope), p (snapped peak), step, hold -> new_env, next_hold.
module envelope_lane_calc
    import video_pkg::*;
#(
    parameter int HIT_THRESHOLD   = 32,
    parameter int HIT_HOLD_FRAMES = 4,
    parameter int HOLD_W          = $clog2(HIT_HOLD_FRAMES + 1)
) (
    input  intensity_t        e,
    input  intensity_t        p,
    input  step_t             step,
    input  logic [HOLD_W-1:0] hold,
    output intensity_t        new_env,
    output logic [HOLD_W-1:0] next_hold
);

    intensity_t step_ext;
    intensity_t decayed;
    logic [INTENSITY_W:0] e_plus_thr;
    logic hit_now;

    assign step_ext = intensity_t'(step);

    // Saturate at zero instead of wrapping.
    assign decayed = (e > step_ext) ? (e - step_ext) : '0;

    assign new_env = (p > decayed) ? p : decayed;

    // One extra bit so e + threshold cannot overflow; compares against pre-decay e.
    assign e_plus_thr = {1'b0, e} + (INTENSITY_W + 1)'(HIT_THRESHOLD);
    assign hit_now    = {1'b0, p} > e_plus_thr;

    always_comb begin
        next_hold = hold;
        if (hit_now) begin
            next_hold = HOLD_W'(HIT_HOLD_FRAMES);
        end else if (hold != '0) begin
            next_hold = hold - HOLD_W'(1);
        end
    end

endmodule

// File: rtl/intensity_envelope.sv
// Frame-rate envelope follower: one shared lane walks the instruments, then all outputs commit at once.
// Ports: clk, rst, new_frame, peak_intensity[], decay_knob -> envelope[], hit[], envelope_valid, frame_overrun.
module intensity_envelope
    import video_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int HIT_THRESHOLD    = 32,
    parameter int HIT_HOLD_FRAMES  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          new_frame,
    input  logic [INSTRUMENT_COUNT-1:0][INTENSITY_W-1:0]  peak_intensity,
    input  logic [KNOB_W-1:0]                             decay_knob,
    output logic [INSTRUMENT_COUNT-1:0][INTENSITY_W-1:0]  envelope,
    output logic [INSTRUMENT_COUNT-1:0]                   hit,
    output logic                                          envelope_valid,
    output logic                                          frame_overrun
);

    localparam int HOLD_W = $clog2(HIT_HOLD_FRAMES + 1);
    localparam int IDX_W  = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTRUMENT_COUNT - 1);

    env_state_t        state;
    logic [IDX_W-1:0]  idx;
    step_t             step;
    intensity_t        snap   [INSTRUMENT_COUNT];
    intensity_t        shadow [INSTRUMENT_COUNT];
    logic [HOLD_W-1:0] hold   [INSTRUMENT_COUNT];

    intensity_t        lane_e;
    intensity_t        lane_p;
    logic [HOLD_W-1:0] lane_hold;
    intensity_t        lane_env;
    logic [HOLD_W-1:0] lane_next_hold;

    // Committed envelope is stable through UPDATE, so it is the lane's "previous" value.
    assign lane_e    = envelope[idx];
    assign lane_p    = snap[idx];
    assign lane_hold = hold[idx];

    envelope_lane_calc #(
        .HIT_THRESHOLD   (HIT_THRESHOLD),
        .HIT_HOLD_FRAMES (HIT_HOLD_FRAMES),
        .HOLD_W          (HOLD_W)
    ) u_lane (
        .e         (lane_e),
        .p         (lane_p),
        .step      (step),
        .hold      (lane_hold),
        .new_env   (lane_env),
        .next_hold (lane_next_hold)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            step           <= '0;
            envelope       <= '0;
            hit            <= '0;
            envelope_valid <= 1'b0;
            frame_overrun  <= 1'b0;
            for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                snap[i]   <= '0;
                shadow[i] <= '0;
                hold[i]   <= '0;
            end
        end else begin
            envelope_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (new_frame) begin
                        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                            snap[i] <= peak_intensity[i];
                        end
                        step  <= knob_to_step(decay_knob);
                        idx   <= '0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (new_frame) begin
                        frame_overrun <= 1'b1;
                    end
                    shadow[idx] <= lane_env;
                    hold[idx]   <= lane_next_hold;
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                COMMIT: begin
                    if (new_frame) begin
                        frame_overrun <= 1'b1;
                    end
                    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                        envelope[i] <= shadow[i];
                        hit[i]      <= (hold[i] != '0);
                    end
                    envelope_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intensity_envelope.sv
// Scoreboard bench for intensity_envelope: directed envelope/hit scenarios plus random frames.
// Expected results come from an arithmetic model of the envelope rules.
module tb_intensity_envelope;

    localparam int N    = 3;
    localparam int THR  = 32;
    localparam int HOLD = 4;
    localparam int LAT  = N + 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                new_frame;
    logic [N-1:0][7:0]   peak_intensity;
    logic [9:0]          decay_knob;
    logic [N-1:0][7:0]   envelope;
    logic [N-1:0]        hit;
    logic                envelope_valid;
    logic                frame_overrun;

    intensity_envelope #(
        .INSTRUMENT_COUNT (N),
        .HIT_THRESHOLD    (THR),
        .HIT_HOLD_FRAMES  (HOLD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .new_frame      (new_frame),
        .peak_intensity (peak_intensity),
        .decay_knob     (decay_knob),
        .envelope       (envelope),
        .hit            (hit),
        .envelope_valid (envelope_valid),
        .frame_overrun  (frame_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int                due;
        logic [N-1:0][7:0] env;
        logic [N-1:0]      hit;
        logic              ovr;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    int env_m  [N];
    int hold_m [N];
    bit ovr_m;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            env_m[i]  = 0;
            hold_m[i] = 0;
        end
        ovr_m = 0;
    endtask

    task automatic model_frame(input logic [N-1:0][7:0] pk, input int rate, output exp_t ex);
        int step, e, p, dec;
        step = rate / 32 + 1;
        for (int i = 0; i < N; i++) begin
            e   = env_m[i];
            p   = int'(pk[i]);
            dec = (e > step) ? e - step : 0;
            if (p > e + THR) hold_m[i] = HOLD;
            else if (hold_m[i] > 0) hold_m[i] = hold_m[i] - 1;
            env_m[i]  = (p > dec) ? p : dec;
            ex.env[i] = 8'(env_m[i]);
            ex.hit[i] = (hold_m[i] != 0);
        end
    endtask

    // overrun_gap > 0 pulses a second new_frame that many cycles after the first.
    task automatic send_frame(input logic [N-1:0][7:0] pk, input int rate, input int overrun_gap);
        exp_t ex;
        @(negedge clk);
        new_frame      = 1'b1;
        peak_intensity = pk;
        decay_knob     = 10'(rate);
        model_frame(pk, rate, ex);
        ex.due = cyc + LAT;
        if (overrun_gap > 0) ovr_m = 1;
        ex.ovr = ovr_m;
        sb.push_back(ex);
        @(negedge clk);
        new_frame      = 1'b0;
        peak_intensity = (N*8)'($urandom);
        decay_knob     = 10'($urandom);
        if (overrun_gap > 0) begin
            repeat (overrun_gap - 1) @(negedge clk);
            new_frame      = 1'b1;
            peak_intensity = (N*8)'($urandom);
            @(negedge clk);
            new_frame = 1'b0;
        end
        while (cyc < ex.due) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (envelope_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got envelope_valid=1 required 0 (cycle %0d)", cyc);
                end else begin
                    exp_t ex;
                    ex = sb.pop_front();
                    check("valid_latency", cyc, ex.due);
                    check("envelope", envelope, ex.env);
                    check("hit", hit, ex.hit);
                    check("frame_overrun", frame_overrun, ex.ovr);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_valid: got no envelope_valid required one at cycle %0d", sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    logic [N-1:0][7:0] pk;

    initial begin
        rst            = 1'b1;
        new_frame      = 1'b0;
        peak_intensity = '0;
        decay_knob     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_envelope", envelope, 0);
        check("rst_hit", hit, 0);
        check("rst_valid", envelope_valid, 0);
        check("rst_overrun", frame_overrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Attack
        send_frame({8'd0, 8'd0, 8'd200}, 0, 0);
        check("attack_env0", envelope[0], 200);
        check("attack_hit", hit, 3'b001);

        // Decay and hold expiry
        for (int f = 1; f <= 5; f++) begin
            send_frame('0, 1023, 0);
            check("decay_env0", envelope[0], 200 - 32 * f);
            check("decay_hit0", hit[0], (f <= 3) ? 1 : 0);
        end

        // Saturating decay
        send_frame({8'd0, 8'd20, 8'd0}, 0, 0);
        check("sat_setup_env1", envelope[1], 20);
        send_frame('0, 1023, 0);
        check("sat_env1", envelope[1], 0);

        // Threshold edge on instrument 2
        send_frame({8'd100, 8'd0, 8'd0}, 1023, 0);
        repeat (4) send_frame({8'd100, 8'd0, 8'd0}, 0, 0);
        check("thr_setup_hit2", hit[2], 0);
        send_frame({8'd132, 8'd0, 8'd0}, 0, 0);
        check("thr132_env2", envelope[2], 132);
        check("thr132_hit2", hit[2], 0);
        send_frame({8'd100, 8'd0, 8'd0}, 1023, 0);
        check("thr_back_env2", envelope[2], 100);
        send_frame({8'd133, 8'd0, 8'd0}, 0, 0);
        check("thr133_hit2", hit[2], 1);
        send_frame({8'd240, 8'd0, 8'd0}, 0, 0);
        repeat (4) send_frame({8'd240, 8'd0, 8'd0}, 0, 0);
        send_frame({8'd255, 8'd0, 8'd0}, 0, 0);
        check("ovf_env2", envelope[2], 255);
        check("ovf_hit2", hit[2], 0);

        // Overrun: second pulse ignored, flag sticky
        send_frame({8'd10, 8'd90, 8'd180}, 300, 2);
        check("overrun_set", frame_overrun, 1);
        send_frame((N*8)'($urandom), int'($urandom_range(0, 1023)), 0);
        check("overrun_sticky", frame_overrun, 1);

        // Reset in the middle of an update
        send_frame({8'd70, 8'd60, 8'd50}, 0, 0);
        @(negedge clk);
        new_frame      = 1'b1;
        peak_intensity = {8'd222, 8'd222, 8'd222};
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_envelope", envelope, 0);
        check("midrst_hit", hit, 0);
        check("midrst_valid", envelope_valid, 0);
        check("midrst_overrun", frame_overrun, 0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("postrst_envelope", envelope, 0);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            pk = (N*8)'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) pk[i] = 8'd0;
            end
            send_frame(pk, int'($urandom_range(0, 1023)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (LAT + 2) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
